// File: rtl/systolic_tile_controller.sv
// -----------------------------------------------------------------------------
// systolic_tile_controller
//
// Sequences one matrix tile through an N x N systolic array:
//   LOAD_A    - streams dim*dim elements of A from memory (row-major).
//   LOAD_B    - same for B; B is exposed transposed on weight_output.
//   EXECUTE   - feeds skewed columns of A on data_up and collects dim result
//               rows reported by the array via result_valid/result_col.
//   WRITEBACK - writes C row-major to memory, optionally clamping negatives.
//   FINISH    - one-cycle done pulse; error reports a bad dim or a timeout.
//
// Ports
//   clk, rst_n            clock (rising edge), async active-low reset
//   start, dim, relu_en   tile request and its configuration (IDLE only)
//   addr_A/addr_B/addr_C  row-major base addresses, wrap modulo 2^AW
//   mem_rdata             read data, valid RD_LAT cycles after its address
//   result_valid          array presents a result row this cycle
//   result_col            result row, element j in bits [j*WIDTH +: WIDTH]
//   mem_addr/we/wdata     shared read/write memory port
//   weight_output         element [i][j] at bits [(i*N+j)*WIDTH +: WIDTH]
//   data_up               registered skewed A feed, element i at [i*WIDTH +: WIDTH]
//   busy, done, error     status
// -----------------------------------------------------------------------------
module systolic_tile_controller #(
  parameter int N            = 4,
  parameter int WIDTH        = 16,
  parameter int AW           = 12,
  parameter int RD_LAT       = 1,
  parameter int EXEC_TIMEOUT = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [3:0]               dim,
  input  logic                     relu_en,
  input  logic [AW-1:0]            addr_A,
  input  logic [AW-1:0]            addr_B,
  input  logic [AW-1:0]            addr_C,
  input  logic [WIDTH-1:0]         mem_rdata,
  input  logic                     result_valid,
  input  logic [N*WIDTH-1:0]       result_col,
  output logic [AW-1:0]            mem_addr,
  output logic                     mem_we,
  output logic [WIDTH-1:0]         mem_wdata,
  output logic [N*N*WIDTH-1:0]     weight_output,
  output logic [N*WIDTH-1:0]       data_up,
  output logic                     busy,
  output logic                     done,
  output logic                     error
);

  localparam int IW = $clog2(N);
  localparam int TW = $clog2(EXEC_TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, EXECUTE, WRITEBACK, FINISH} state_t;

  state_t state_reg, state_next;

  // Latched tile configuration
  logic [3:0]    dim_reg;
  logic          relu_reg;
  logic [AW-1:0] base_a_reg, base_b_reg, base_c_reg;

  // Operand and result storage (cleared at every accepted start)
  logic [WIDTH-1:0] a_mem [N][N];
  logic [WIDTH-1:0] b_mem [N][N];
  logic [WIDTH-1:0] c_mem [N][N];

  // Sequencing counters
  logic [6:0]        iss_cnt_reg;
  logic [IW-1:0]     cap_row_reg, cap_col_reg;
  logic [RD_LAT-1:0] vpipe_reg;
  logic [TW-1:0]     t_reg;
  logic [IW-1:0]     res_row_reg;
  logic [IW-1:0]     wb_row_reg, wb_col_reg;
  logic [6:0]        wb_cnt_reg;
  logic              error_reg;
  logic [N*WIDTH-1:0] data_up_reg;
  logic [N*WIDTH-1:0] feed_vec;

  logic [6:0]       total;
  logic             dim_ok, accept, loading, issuing;
  logic             cap_fire, cap_last, res_fire, res_last, wb_last;
  logic [WIDTH-1:0] wb_val;

  assign total    = 7'(dim_reg) * 7'(dim_reg);
  assign dim_ok   = (dim != 4'd0) && (dim <= 4'(N));
  assign accept   = (state_reg == IDLE) && start && dim_ok;
  assign loading  = (state_reg == LOAD_A) || (state_reg == LOAD_B);
  assign issuing  = loading && (iss_cnt_reg < total);
  // vpipe tracks which past cycles carried a read address; its oldest stage
  // lines up with the cycle that address's data is on mem_rdata.
  assign cap_fire = loading && vpipe_reg[RD_LAT-1];
  assign cap_last = (cap_row_reg == IW'(dim_reg - 4'd1)) && (cap_col_reg == IW'(dim_reg - 4'd1));
  assign res_fire = (state_reg == EXECUTE) && result_valid;
  assign res_last = (res_row_reg == IW'(dim_reg - 4'd1));
  assign wb_last  = (wb_cnt_reg == total - 7'd1);
  assign wb_val   = c_mem[wb_row_reg][wb_col_reg];

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    mem_addr   = '0;
    mem_we     = 1'b0;
    mem_wdata  = '0;
    busy       = (state_reg != IDLE);
    done       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) state_next = dim_ok ? LOAD_A : FINISH;
      end
      LOAD_A: begin
        if (issuing) mem_addr = base_a_reg + AW'(iss_cnt_reg);
        if (cap_fire && cap_last) state_next = LOAD_B;
      end
      LOAD_B: begin
        if (issuing) mem_addr = base_b_reg + AW'(iss_cnt_reg);
        if (cap_fire && cap_last) state_next = EXECUTE;
      end
      EXECUTE: begin
        // A final row arriving on the last allowed cycle still wins.
        if (res_fire && res_last)                    state_next = WRITEBACK;
        else if (t_reg == TW'(EXEC_TIMEOUT - 1))     state_next = FINISH;
      end
      WRITEBACK: begin
        mem_we    = 1'b1;
        mem_addr  = base_c_reg + AW'(wb_cnt_reg);
        mem_wdata = (relu_reg && wb_val[WIDTH-1]) ? '0 : wb_val;
        if (wb_last) state_next = FINISH;
      end
      FINISH: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // ----------------------------------------------------- config + counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dim_reg     <= '0;
      relu_reg    <= 1'b0;
      base_a_reg  <= '0;
      base_b_reg  <= '0;
      base_c_reg  <= '0;
      iss_cnt_reg <= '0;
      cap_row_reg <= '0;
      cap_col_reg <= '0;
      vpipe_reg   <= '0;
      t_reg       <= '0;
      res_row_reg <= '0;
      wb_row_reg  <= '0;
      wb_col_reg  <= '0;
      wb_cnt_reg  <= '0;
    end else begin
      vpipe_reg <= (vpipe_reg << 1) | RD_LAT'(issuing);
      if (accept) begin
        dim_reg    <= dim;
        relu_reg   <= relu_en;
        base_a_reg <= addr_A;
        base_b_reg <= addr_B;
        base_c_reg <= addr_C;
      end
      // Every state starts its counters from zero.
      if (state_next != state_reg) begin
        iss_cnt_reg <= '0;
        cap_row_reg <= '0;
        cap_col_reg <= '0;
        t_reg       <= '0;
        res_row_reg <= '0;
        wb_row_reg  <= '0;
        wb_col_reg  <= '0;
        wb_cnt_reg  <= '0;
      end else begin
        if (issuing) iss_cnt_reg <= iss_cnt_reg + 7'd1;
        if (cap_fire) begin
          if (cap_col_reg == IW'(dim_reg - 4'd1)) begin
            cap_col_reg <= '0;
            cap_row_reg <= cap_row_reg + 1'b1;
          end else begin
            cap_col_reg <= cap_col_reg + 1'b1;
          end
        end
        if (state_reg == EXECUTE) t_reg <= t_reg + 1'b1;
        if (res_fire) res_row_reg <= res_row_reg + 1'b1;
        if (state_reg == WRITEBACK) begin
          wb_cnt_reg <= wb_cnt_reg + 7'd1;
          if (wb_col_reg == IW'(dim_reg - 4'd1)) begin
            wb_col_reg <= '0;
            wb_row_reg <= wb_row_reg + 1'b1;
          end else begin
            wb_col_reg <= wb_col_reg + 1'b1;
          end
        end
      end
    end
  end

  // ------------------------------------------------------ matrix storage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < N; r++)
        for (int c = 0; c < N; c++) begin
          a_mem[r][c] <= '0;
          b_mem[r][c] <= '0;
          c_mem[r][c] <= '0;
        end
    end else if (accept) begin
      for (int r = 0; r < N; r++)
        for (int c = 0; c < N; c++) begin
          a_mem[r][c] <= '0;
          b_mem[r][c] <= '0;
          c_mem[r][c] <= '0;
        end
    end else begin
      if (cap_fire && (state_reg == LOAD_A)) a_mem[cap_row_reg][cap_col_reg] <= mem_rdata;
      if (cap_fire && (state_reg == LOAD_B)) b_mem[cap_row_reg][cap_col_reg] <= mem_rdata;
      if (res_fire) begin
        for (int j = 0; j < N; j++)
          if (j < int'(dim_reg)) c_mem[res_row_reg][j] <= result_col[j*WIDTH +: WIDTH];
      end
    end
  end

  // ------------------------------------------------------ error status
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                               error_reg <= 1'b0;
    else if (accept)                                          error_reg <= 1'b0;
    else if ((state_reg == IDLE) && start)                    error_reg <= 1'b1;
    else if ((state_reg == EXECUTE) && (state_next == FINISH)) error_reg <= 1'b1;
  end

  assign error = error_reg;

  // --------------------------------------------------- skewed A feed
  // Lane i carries column i of A delayed by i cycles: A[t-i][i].
  for (genvar gi = 0; gi < N; gi++) begin : g_feed
    logic [TW-1:0] diff;
    logic          feed_ok;
    assign diff    = t_reg - TW'(gi);
    assign feed_ok = (state_reg == EXECUTE) && (gi < int'(dim_reg)) &&
                     (int'(t_reg) >= gi) && (int'(diff) < int'(dim_reg));
    assign feed_vec[gi*WIDTH +: WIDTH] = feed_ok ? a_mem[diff[IW-1:0]][gi] : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) data_up_reg <= '0;
    else        data_up_reg <= feed_vec;
  end

  assign data_up = data_up_reg;

  // ----------------------------------------------- transposed weights
  for (genvar gi = 0; gi < N; gi++) begin : g_wrow
    for (genvar gj = 0; gj < N; gj++) begin : g_wcol
      assign weight_output[(gi*N+gj)*WIDTH +: WIDTH] = b_mem[gj][gi];
    end
  end

endmodule

// File: tb/tb_systolic_tile_controller.sv
`timescale 1ns/1ps
module tb_systolic_tile_controller;
  localparam int N  = 4;
  localparam int W  = 16;
  localparam int AW = 12;
  localparam int RL = 3;
  localparam int TO = 64;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [3:0]        dim = '0;
  logic              relu_en = 1'b0;
  logic [AW-1:0]     addr_A = '0, addr_B = '0, addr_C = '0;
  logic [W-1:0]      mem_rdata;
  logic              result_valid = 1'b0;
  logic [N*W-1:0]    result_col = '0;
  logic [AW-1:0]     mem_addr;
  logic              mem_we;
  logic [W-1:0]      mem_wdata;
  logic [N*N*W-1:0]  weight_output;
  logic [N*W-1:0]    data_up;
  logic              busy, done, error;

  always #5 clk = ~clk;

  systolic_tile_controller #(.N(N), .WIDTH(W), .AW(AW), .RD_LAT(RL), .EXEC_TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dim(dim), .relu_en(relu_en),
    .addr_A(addr_A), .addr_B(addr_B), .addr_C(addr_C), .mem_rdata(mem_rdata),
    .result_valid(result_valid), .result_col(result_col), .mem_addr(mem_addr),
    .mem_we(mem_we), .mem_wdata(mem_wdata), .weight_output(weight_output),
    .data_up(data_up), .busy(busy), .done(done), .error(error));

  int total = 0;
  int bad = 0;
  int done_cnt = 0;

  typedef struct {
    logic [AW-1:0] addr;
    logic [W-1:0]  data;
  } wr_t;
  wr_t exp_q[$];

  logic [W-1:0] mem [4096];
  logic [W-1:0] rd_pipe [RL];
  int a_m [N][N];
  int b_m [N][N];
  int rows [N][N];

  function automatic void chk(string tag, logic [63:0] got, logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endfunction

  // Memory model: read data appears RL cycles after its address.
  always @(posedge clk) begin
    rd_pipe[0] <= mem[mem_addr];
    for (int k = 1; k < RL; k++) rd_pipe[k] <= rd_pipe[k-1];
  end
  assign mem_rdata = rd_pipe[RL-1];

  // Write monitor: every write must match the head of the scoreboard.
  always @(negedge clk) begin : mon
    wr_t e;
    if (done === 1'b1) done_cnt++;
    if (mem_we !== 1'b0) begin
      chk("write_expected", 64'(exp_q.size() > 0), 64'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("wr_addr", 64'(mem_addr), 64'(e.addr));
        chk("wr_data", 64'(mem_wdata), 64'(e.data));
        $display("write addr=%03h data=%04h", mem_addr, mem_wdata);
      end
    end
  end

  task automatic push_exp(logic [AW-1:0] a, int d);
    wr_t e;
    e.addr = a;
    e.data = W'(d);
    exp_q.push_back(e);
  endtask

  task automatic load_mats(int d, logic [AW-1:0] aa, logic [AW-1:0] ab);
    logic [AW-1:0] ad;
    for (int r = 0; r < d; r++)
      for (int c = 0; c < d; c++) begin
        ad = aa + AW'(r*d + c); mem[ad] = W'(a_m[r][c]);
        ad = ab + AW'(r*d + c); mem[ad] = W'(b_m[r][c]);
      end
  endtask

  // Reference product standing in for the systolic array.
  task automatic model_rows(int d);
    for (int r = 0; r < d; r++)
      for (int c = 0; c < d; c++) begin
        rows[r][c] = 0;
        for (int k = 0; k < d; k++) rows[r][c] += a_m[r][k] * b_m[k][c];
      end
  endtask

  task automatic launch(int d, logic relu, logic [AW-1:0] aa, logic [AW-1:0] ab, logic [AW-1:0] ac);
    @(negedge clk);
    dim = 4'(d); relu_en = relu; addr_A = aa; addr_B = ab; addr_C = ac; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    $display("start dim=%0d relu=%0d A=%03h B=%03h C=%03h", d, relu, aa, ab, ac);
  endtask

  task automatic wait_exec();
    int n = 0;
    while (data_up === '0 && n < 300) begin @(negedge clk); n++; end
    chk("exec_reached", 64'(data_up !== '0), 64'd1);
  endtask

  task automatic feed_rows(int d);
    logic [N*W-1:0] v;
    for (int r = 0; r < d; r++) begin
      v = '0;
      for (int c = 0; c < d; c++) v[c*W +: W] = W'(rows[r][c]);
      result_col = v; result_valid = 1'b1;
      @(negedge clk);
    end
    result_valid = 1'b0; result_col = '0;
  endtask

  task automatic finish_tile(logic exp_err, int base_done, output int n);
    n = 0;
    while (done !== 1'b1 && n < 400) begin @(negedge clk); n++; end
    chk("done_seen", 64'(done), 64'd1);
    chk("error_at_done", 64'(error), 64'(exp_err));
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    @(negedge clk); #1;
    chk("done_one_cycle", 64'(done), 64'd0);
    chk("idle_after", 64'(busy), 64'd0);
    chk("done_count", 64'(done_cnt - base_done), 64'd1);
    $display("tile finished error=%0d cycles=%0d", error, n);
  endtask

  initial begin
    int base, n;
    for (int i = 0; i < 4096; i++) mem[i] = '0;
    for (int k = 0; k < RL; k++) rd_pipe[k] = '0;
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_we", 64'(mem_we), 64'd0);
    chk("rst_addr", 64'(mem_addr), 64'd0);
    chk("rst_wdata", 64'(mem_wdata), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_error", 64'(error), 64'd0);
    chk("rst_data_up", 64'(data_up), 64'd0);
    chk("rst_weights", 64'(|weight_output), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // dim=4, A = identity, B[r][c] = 4r+c -> C = B
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin a_m[r][c] = (r == c) ? 1 : 0; b_m[r][c] = 4*r + c; end
    load_mats(4, 12'h100, 12'h200);
    model_rows(4);
    for (int k = 0; k < 16; k++) push_exp(12'h400 + AW'(k), k);
    base = done_cnt;
    launch(4, 1'b0, 12'h100, 12'h200, 12'h400);
    wait_exec();
    chk("id_du_t0", 64'(data_up), 64'h1);
    chk("wo_0_1", 64'(weight_output[(0*N+1)*W +: W]), 64'd4);
    chk("wo_2_3", 64'(weight_output[(2*N+3)*W +: W]), 64'd14);
    chk("wo_3_0", 64'(weight_output[(3*N+0)*W +: W]), 64'd3);
    feed_rows(4);
    finish_tile(1'b0, base, n);

    // dim=2, A=[[1,2],[3,4]], B=[[5,6],[7,8]], C wraps past top of memory;
    // a start during LOAD_A is ignored
    a_m[0][0] = 1; a_m[0][1] = 2; a_m[1][0] = 3; a_m[1][1] = 4;
    b_m[0][0] = 5; b_m[0][1] = 6; b_m[1][0] = 7; b_m[1][1] = 8;
    load_mats(2, 12'h110, 12'h210);
    model_rows(2);
    push_exp(12'hFFE, 19); push_exp(12'hFFF, 22); push_exp(12'h000, 43); push_exp(12'h001, 50);
    base = done_cnt;
    launch(2, 1'b0, 12'h110, 12'h210, 12'hFFE);
    dim = 4'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_exec();
    chk("skew_t0", 64'(data_up), 64'h0000_0000_0000_0001);
    @(negedge clk);
    chk("skew_t1", 64'(data_up), 64'h0000_0000_0002_0003);
    @(negedge clk);
    chk("skew_t2", 64'(data_up), 64'h0000_0000_0004_0000);
    feed_rows(2);
    finish_tile(1'b0, base, n);
    chk("du_cleared", 64'(data_up), 64'd0);

    // relu: rows [-5,3],[0,-1] -> 0,3,0,0
    a_m[0][0] = 1; a_m[0][1] = 0; a_m[1][0] = 0; a_m[1][1] = 1;
    load_mats(2, 12'h120, 12'h220);
    rows[0][0] = -5; rows[0][1] = 3; rows[1][0] = 0; rows[1][1] = -1;
    push_exp(12'h430, 0); push_exp(12'h431, 3); push_exp(12'h432, 0); push_exp(12'h433, 0);
    base = done_cnt;
    launch(2, 1'b1, 12'h120, 12'h220, 12'h430);
    wait_exec();
    feed_rows(2);
    finish_tile(1'b0, base, n);

    // illegal dims: straight to FINISH, no memory access
    for (int s = 0; s < 2; s++) begin
      base = done_cnt;
      launch((s == 0) ? 0 : 5, 1'b0, 12'h100, 12'h200, 12'h400);
      chk("bad_dim_done", 64'(done), 64'd1);
      chk("bad_dim_error", 64'(error), 64'd1);
      chk("bad_dim_addr", 64'(mem_addr), 64'd0);
      @(negedge clk); #1;
      chk("bad_dim_idle", 64'(busy), 64'd0);
      chk("bad_dim_err_held", 64'(error), 64'd1);
      chk("bad_dim_done_cnt", 64'(done_cnt - base), 64'd1);
    end

    // timeout: no result rows; LOAD_A/LOAD_B take 4+3 cycles each
    base = done_cnt;
    launch(2, 1'b0, 12'h110, 12'h210, 12'h440);
    finish_tile(1'b1, base, n);
    chk("timeout_latency", 64'(n), 64'(2*(4 + RL) + TO));
    repeat (3) @(negedge clk);
    chk("error_held", 64'(error), 64'd1);

    // reset while the fourth write is on the bus; the accepted start clears error
    a_m[0][0] = 1; a_m[0][1] = 0; a_m[1][0] = 0; a_m[1][1] = 1;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin a_m[r][c] = (r == c) ? 1 : 0; b_m[r][c] = 4*r + c; end
    load_mats(4, 12'h100, 12'h200);
    model_rows(4);
    for (int k = 0; k < 4; k++) push_exp(12'h600 + AW'(k), k);
    launch(4, 1'b0, 12'h100, 12'h200, 12'h600);
    chk("start_clears_error", 64'(error), 64'd0);
    wait_exec();
    feed_rows(4);
    n = 0;
    while (!(mem_we === 1'b1 && mem_addr === 12'h603) && n < 200) begin @(negedge clk); n++; end
    chk("write3_reached", 64'(mem_addr), 64'h603);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_we", 64'(mem_we), 64'd0);
    chk("mid_rst_addr", 64'(mem_addr), 64'd0);
    chk("mid_rst_wdata", 64'(mem_wdata), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_weights", 64'(|weight_output), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk("mid_rst_queue", 64'(exp_q.size()), 64'd0);
    repeat (5) @(negedge clk);

    // normal tile after reset
    a_m[0][0] = 1; a_m[0][1] = 2; a_m[1][0] = 3; a_m[1][1] = 4;
    b_m[0][0] = 5; b_m[0][1] = 6; b_m[1][0] = 7; b_m[1][1] = 8;
    load_mats(2, 12'h110, 12'h210);
    model_rows(2);
    push_exp(12'h700, 19); push_exp(12'h701, 22); push_exp(12'h702, 43); push_exp(12'h703, 50);
    base = done_cnt;
    launch(2, 1'b0, 12'h110, 12'h210, 12'h700);
    wait_exec();
    feed_rows(2);
    finish_tile(1'b0, base, n);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
